// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: FSM states and default clock rates.
package i2c_pkg;

   localparam int unsigned SYS_FREQ_DEF = 100_000_000;
   localparam int unsigned I2C_FREQ_DEF = 400_000;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      MST_NACK,
      STOP
   } state_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: one tick every Q clocks and a 2-bit phase that wraps once per bit.
module i2c_tick_gen #(
   parameter int unsigned Q = 62
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int unsigned CW = (Q > 1) ? $clog2(Q) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(Q - 1));

   // Held at zero while disabled so every transaction starts on a clean phase 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= '0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= '0;
      end else if (tick) begin
         cnt   <= '0;
         phase <= phase + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master (write or read) with open-drain SDA and push-pull SCL.
module i2c_master_fsm
   import i2c_pkg::*;
#(
   parameter int unsigned SYS_FREQ = SYS_FREQ_DEF,
   parameter int unsigned I2C_FREQ = I2C_FREQ_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic [6:0] address,
   input  logic       rw,
   input  logic [7:0] din,
   output logic [7:0] dout,
   inout  wire        sda,
   output logic       sclk,
   output logic       busy,
   output logic       done,
   output logic       ack_err
);

   localparam int unsigned Q = SYS_FREQ / (4 * I2C_FREQ);

   state_t     state, state_n;
   logic       tick;
   logic [1:0] phase;
   logic       bit_end, sample_pt;
   logic [2:0] bit_cnt;
   logic [7:0] tx_sh, rx_sh, din_q;
   logic       rw_q, sampled, sda_in;
   logic       sda_low, sda_low_n, scl_n;

   i2c_tick_gen #(.Q(Q)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (state != IDLE),
      .tick  (tick),
      .phase (phase)
   );

   assign bit_end   = tick && (phase == 2'd3);
   assign sample_pt = tick && (phase == 2'd2);
   assign busy      = (state != IDLE);
   assign sda       = sda_low ? 1'b0 : 1'bz;

   // Anything other than a solid 0 (including an undriven line) reads as 1.
   always_comb begin
      sda_in = 1'b1;
      if (sda == 1'b0) sda_in = 1'b0;
   end

   always_comb begin
      state_n   = state;
      scl_n     = (phase == 2'd1) || (phase == 2'd2);
      sda_low_n = 1'b0;
      case (state)
         IDLE: begin
            scl_n = 1'b1;
            if (trigger) state_n = START;
         end
         START: begin
            scl_n     = (phase != 2'd3);
            sda_low_n = (phase != 2'd0);
            if (bit_end) state_n = ADDR;
         end
         ADDR: begin
            sda_low_n = ~tx_sh[7];
            if (bit_end && bit_cnt == 3'd7) state_n = ADDR_ACK;
         end
         ADDR_ACK: begin
            if (bit_end) state_n = sampled ? STOP : (rw_q ? RD_DATA : WR_DATA);
         end
         WR_DATA: begin
            sda_low_n = ~tx_sh[7];
            if (bit_end && bit_cnt == 3'd7) state_n = WR_ACK;
         end
         WR_ACK: begin
            if (bit_end) state_n = STOP;
         end
         RD_DATA: begin
            if (bit_end && bit_cnt == 3'd7) state_n = MST_NACK;
         end
         MST_NACK: begin
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            scl_n     = (phase != 2'd0);
            sda_low_n = (phase == 2'd0) || (phase == 2'd1);
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Bus pins are registered so SCL and SDA move together, one clock after the phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sclk    <= 1'b1;
         sda_low <= 1'b0;
         dout    <= 8'h00;
         done    <= 1'b0;
         ack_err <= 1'b0;
         bit_cnt <= 3'd0;
      end else begin
         state   <= state_n;
         sclk    <= scl_n;
         sda_low <= sda_low_n;
         done    <= (state == STOP) && bit_end;
         if (state == IDLE && trigger)
            ack_err <= 1'b0;
         else if (bit_end && (state == ADDR_ACK || state == WR_ACK) && sampled)
            ack_err <= 1'b1;
         if (state == IDLE)
            bit_cnt <= 3'd0;
         else if (bit_end && (state == ADDR || state == WR_DATA || state == RD_DATA))
            bit_cnt <= bit_cnt + 3'd1;
         if (sample_pt && state == RD_DATA && bit_cnt == 3'd7)
            dout <= {rx_sh[6:0], sda_in};
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && trigger) begin
         tx_sh <= {address, rw};
         din_q <= din;
         rw_q  <= rw;
      end else if (bit_end && state == ADDR_ACK) begin
         tx_sh <= din_q;
      end else if (bit_end && (state == ADDR || state == WR_DATA)) begin
         tx_sh <= {tx_sh[6:0], 1'b0};
      end
      if (sample_pt) sampled <= sda_in;
      if (sample_pt && state == RD_DATA) rx_sh <= {rx_sh[6:0], sda_in};
   end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm with a bus-level slave model and START/STOP counting.
module tb_i2c_master_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trigger = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] address = 7'h00;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       sclk, busy, done, ack_err;
   wire        sda;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   // Slave model state
   logic       slave_low = 1'b0;
   logic       slave_ack_en = 1'b1;
   logic [7:0] slave_tx = 8'h00;
   logic       in_xfer = 1'b0;
   int         bitn = 0;
   int         start_cnt = 0;
   int         stop_cnt = 0;
   logic [7:0] addr_byte = 8'h00;
   logic [7:0] data_byte = 8'h00;
   logic [7:0] dout_at8 = 8'h00;
   logic       ack_bit = 1'b0;
   logic       last_bit = 1'b0;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   i2c_master_fsm dut (
      .clk     (clk),
      .rst     (rst),
      .trigger (trigger),
      .address (address),
      .rw      (rw),
      .din     (din),
      .dout    (dout),
      .sda     (sda),
      .sclk    (sclk),
      .busy    (busy),
      .done    (done),
      .ack_err (ack_err)
   );

   always #5 clk = ~clk;

   // Any SDA edge while SCL is high must be a START (fall) or STOP (rise); counts expose strays.
   always @(negedge sda) begin
      if (sclk === 1'b1) begin
         start_cnt++;
         in_xfer = 1'b1;
         bitn    = 0;
      end
   end

   always @(posedge sda) begin
      if (sclk === 1'b1) begin
         stop_cnt++;
         in_xfer   = 1'b0;
         slave_low = 1'b0;
      end
   end

   always @(posedge sclk) begin
      if (in_xfer) begin
         bitn++;
         if (bitn <= 8)       addr_byte = {addr_byte[6:0], sda};
         else if (bitn == 9)  ack_bit = sda;
         else if (bitn <= 17) data_byte = {data_byte[6:0], sda};
         else if (bitn == 18) last_bit = sda;
         if (bitn == 17) dout_at8 = dout;
      end
   end

   always @(negedge sclk) begin
      if (in_xfer) begin
         slave_low = 1'b0;
         if (bitn == 8)
            slave_low = slave_ack_en;
         else if (bitn >= 9 && bitn <= 16 && addr_byte[0])
            slave_low = ~slave_tx[16 - bitn];
         else if (bitn == 17 && !addr_byte[0])
            slave_low = slave_ack_en;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                          input int guard_at, output int cycles);
      @(negedge clk);
      address   = a;
      rw        = r;
      din       = d;
      trigger   = 1'b1;
      start_cnt = 0;
      stop_cnt  = 0;
      bitn      = 0;
      addr_byte = 8'h00;
      data_byte = 8'h00;
      @(posedge clk); #1;
      chk("busy_at_accept", {31'd0, busy}, 32'd1);
      chk("ack_err_cleared_at_accept", {31'd0, ack_err}, 32'd0);
      cycles = 0;
      while (done !== 1'b1 && cycles < 6000) begin
         @(posedge clk); #1;
         cycles++;
         if (cycles == 1) trigger = 1'b0;
         if (cycles == guard_at) begin
            trigger = 1'b1;
            address = 7'h12;
            din     = 8'h00;
         end
         if (cycles == guard_at + 3) trigger = 1'b0;
      end
      chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("done_single_cycle", {31'd0, done}, 32'd0);
      chk("idle_sclk_high", {31'd0, sclk}, 32'd1);
      chk("idle_sda_released", {31'd0, sda}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("por_sclk", {31'd0, sclk}, 32'd1);
      chk("por_sda", {31'd0, sda}, 32'd1);
      chk("por_busy", {31'd0, busy}, 32'd0);
      chk("por_done", {31'd0, done}, 32'd0);
      chk("por_dout", {24'd0, dout}, 32'h00);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-transfer: address bit 5 of 0xA0 is 0, so SCL is low and SDA driven low here
      @(negedge clk);
      address = 7'h50; rw = 1'b0; din = 8'hA5; trigger = 1'b1;
      @(posedge clk); #1;
      trigger = 1'b0;
      repeat (1500) @(posedge clk);
      #3;
      chk("pre_rst_sclk_low", {31'd0, sclk}, 32'd0);
      chk("pre_rst_sda_low", {31'd0, sda}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_sclk", {31'd0, sclk}, 32'd1);
      chk("mid_rst_sda", {31'd0, sda}, 32'd1);
      chk("mid_rst_dout", {24'd0, dout}, 32'h00);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_ack_err", {31'd0, ack_err}, 32'd0);
      in_xfer   = 1'b0;
      slave_low = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);

      // Write 0xA5 to 0x50 with an ACKing slave
      slave_ack_en = 1'b1;
      run_txn(7'h50, 1'b0, 8'hA5, 0, cyc);
      chk("wr_addr_byte", {24'd0, addr_byte}, 32'hA0);
      chk("wr_data_byte", {24'd0, data_byte}, 32'hA5);
      chk("wr_addr_ack", {31'd0, ack_bit}, 32'd0);
      chk("wr_data_ack", {31'd0, last_bit}, 32'd0);
      chk("wr_cycles", cyc, 32'd4960);
      chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
      chk("wr_starts", start_cnt, 32'd1);
      chk("wr_stops", stop_cnt, 32'd1);

      // Read from 0x50, slave returns 0x3C
      slave_tx = 8'h3C;
      run_txn(7'h50, 1'b1, 8'h00, 0, cyc);
      chk("rd_addr_byte", {24'd0, addr_byte}, 32'hA1);
      chk("rd_dout_before_8th", {24'd0, dout_at8}, 32'h00);
      chk("rd_dout", {24'd0, dout}, 32'h3C);
      chk("rd_master_nack", {31'd0, last_bit}, 32'd1);
      chk("rd_cycles", cyc, 32'd4960);
      chk("rd_ack_err", {31'd0, ack_err}, 32'd0);
      chk("rd_starts", start_cnt, 32'd1);
      chk("rd_stops", stop_cnt, 32'd1);

      // No slave: address NACK, STOP straight after the ACK slot
      slave_ack_en = 1'b0;
      run_txn(7'h50, 1'b0, 8'hA5, 0, cyc);
      chk("nack_ack_bit", {31'd0, ack_bit}, 32'd1);
      chk("nack_ack_err", {31'd0, ack_err}, 32'd1);
      chk("nack_cycles", cyc, 32'd2728);
      chk("nack_scl_pulses", bitn, 32'd10);
      chk("nack_starts", start_cnt, 32'd1);
      chk("nack_stops", stop_cnt, 32'd1);
      chk("nack_dout_kept", {24'd0, dout}, 32'h3C);

      // Re-trigger and input changes while busy must not disturb the write
      slave_ack_en = 1'b1;
      run_txn(7'h50, 1'b0, 8'hA5, 1000, cyc);
      chk("guard_addr_byte", {24'd0, addr_byte}, 32'hA0);
      chk("guard_data_byte", {24'd0, data_byte}, 32'hA5);
      chk("guard_cycles", cyc, 32'd4960);
      chk("guard_ack_err", {31'd0, ack_err}, 32'd0);
      repeat (300) @(posedge clk);
      #1;
      chk("guard_no_second_txn_busy", {31'd0, busy}, 32'd0);
      chk("guard_starts", start_cnt, 32'd1);
      chk("guard_stops", stop_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
